// File: rtl/updown_cmd_arbiter.sv
// Round-robin arbiter that lets NREQ agents share one bounded up/down/load count register.
// One command is accepted per cycle; a tagged response follows on the next cycle.
module updown_cmd_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MIN_VAL = 2,
  parameter int unsigned MAX_VAL = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [WIDTH*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          count,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_count,
  output logic                      rsp_wrap,
  output logic                      rsp_err
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] MinV = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
  localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

  typedef enum logic [1:0] {
    OpRead = 2'b00,
    OpUp   = 2'b01,
    OpDown = 2'b10,
    OpLoad = 2'b11
  } op_e;

  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   grant_id, scan_id;
  logic             accept;
  op_e              op_sel;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_d, err_d;

  // Scan from rr_ptr upward (mod NREQ); first valid requester wins.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    scan_id   = '0;
    accept    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_id = IdW'((32'(rr_ptr_q) + k) % NREQ);
      if (!accept && req_valid[scan_id]) begin
        accept             = 1'b1;
        grant_id           = scan_id;
        req_ready[scan_id] = 1'b1;
      end
    end
  end

  always_comb begin
    op_sel   = OpRead;
    data_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IdW'(i)) begin
        op_sel   = op_e'(req_op[2*i +: 2]);
        data_sel = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (op_sel)
      OpRead: count_d = count_q;
      OpUp: begin
        if (count_q < MaxV) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = MinV;
          wrap_d  = 1'b1;
        end
      end
      OpDown: begin
        if (count_q > MinV) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = MaxV;
          wrap_d  = 1'b1;
        end
      end
      OpLoad: begin
        if (data_sel >= MinV && data_sel <= MaxV) begin
          count_d = data_sel;
        end else begin
          err_d = 1'b1;
        end
      end
      default: count_d = count_q;
    endcase
  end

  assign rr_ptr_d = (grant_id == LastId) ? '0 : grant_id + IdW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= MinV;
      rr_ptr_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_wrap  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= MinV;
    end else begin
      rsp_valid <= accept;
      rsp_wrap  <= accept & wrap_d;
      rsp_err   <= accept & err_d;
      if (accept) begin
        count_q   <= count_d;
        rr_ptr_q  <= rr_ptr_d;
        rsp_id    <= grant_id;
        rsp_count <= count_d;
      end
    end
  end

  assign count = count_q;

endmodule
